// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator.
// Takes one 8-bit pixel per accepted cycle in raster order. Two image rows are
// held in a linear delay line. For each pixel it emits one zero-padded 3x3
// window centred on that pixel. After the last pixel of a frame it flushes by
// itself, so exactly WIDTH*HEIGHT windows leave per frame.

module window_3x3_gen #(
    parameter int unsigned WIDTH  = 32'd410,
    parameter int unsigned HEIGHT = 32'd361
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic [71:0] window_out,
    output logic        win_valid,
    output logic        busy,
    output logic        frame_done
);

    // Delay-line length counted in offsets. Offset 0 is the incoming byte and
    // is never stored: it is the pixel being accepted, or a zero during flush.
    localparam int unsigned DEPTH = 2 * WIDTH + 3;
    localparam int unsigned CNT_W = $clog2(WIDTH * HEIGHT + 1);

    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  in_cnt_reg;
    logic [CNT_W-1:0]  cr_reg;
    logic [CNT_W-1:0]  cc_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;

    logic [71:0]       window_reg;
    logic              win_valid_reg;
    logic              busy_reg;
    logic              frame_done_reg;

    // line_reg[i] holds the sample at offset i. The stored offsets are
    // 0..DEPTH-2. On a shift, each stored offset moves up by one.
    logic [7:0]        line_reg  [DEPTH-1];
    // Contents of the line as they will be right after this edge's shift.
    logic [7:0]        line_next [DEPTH];

    logic              flushing;
    logic              accept;
    logic              shift_en;
    logic              row_top;
    logic              row_bot;
    logic              col_left;
    logic              col_right;
    logic [71:0]       win_next;

    assign flushing = (state_reg == ST_FLUSH);
    assign accept   = pix_valid && !flushing;
    assign shift_en = accept || flushing;

    // The padding mask depends only on the position of the centre.
    assign row_top   = (cr_reg == '0);
    assign row_bot   = (cr_reg == ROW_LAST);
    assign col_left  = (cc_reg == '0);
    assign col_right = (cc_reg == COL_LAST);

    // During flush, zeros are shifted in so the tail of the last row drains out.
    assign line_next[0] = flushing ? 8'd0 : pix_in;

    genvar gi, gj;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_line_next
            assign line_next[gi] = line_reg[gi-1];
        end
    endgenerate

    // Window taps come from the post-shift line. That way the window leaves on
    // the same edge that accepts its newest neighbour, which is the pixel at
    // (r+1, c+1).
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            for (gj = 0; gj < 3; gj++) begin : g_win_col
                localparam int unsigned OFF = (2 - gi) * WIDTH + (2 - gj);
                localparam int unsigned BYTE_IDX = 3 * gi + gj;
                logic zero_tap;
                assign zero_tap = ((gi == 0) && row_top)  ||
                                  ((gi == 2) && row_bot)  ||
                                  ((gj == 0) && col_left) ||
                                  ((gj == 2) && col_right);
                assign win_next[8*BYTE_IDX +: 8] = zero_tap ? 8'd0 : line_next[OFF];
            end
        end
    endgenerate

    // Delay line: a plain shift register with no reset. Its contents at frame
    // start never reach a window, because the row/column masking hides them.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                line_reg[i] <= line_next[i];
            end
        end
    end

    // Frame sequencer: the FILL/RUN/FLUSH control, the centre counters and the
    // registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_FILL;
            in_cnt_reg     <= '0;
            cr_reg         <= '0;
            cc_reg         <= '0;
            flush_cnt_reg  <= '0;
            window_reg     <= 72'd0;
            win_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_FILL: begin
                    if (accept) begin
                        in_cnt_reg <= in_cnt_reg + CNT_ONE;
                        if (in_cnt_reg == FILL_LAST) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        in_cnt_reg    <= in_cnt_reg + CNT_ONE;
                        window_reg    <= win_next;
                        win_valid_reg <= 1'b1;
                        if (cc_reg == COL_LAST) begin
                            cc_reg <= '0;
                            cr_reg <= cr_reg + CNT_ONE;
                        end else begin
                            cc_reg <= cc_reg + CNT_ONE;
                        end
                        // The last pixel of the frame starts the self-flush.
                        if (in_cnt_reg == LAST_PIX) begin
                            state_reg     <= ST_FLUSH;
                            busy_reg      <= 1'b1;
                            flush_cnt_reg <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    window_reg    <= win_next;
                    win_valid_reg <= 1'b1;
                    if (flush_cnt_reg == FLUSH_LAST) begin
                        // The final window of the frame. Clear everything so the
                        // next frame starts clean.
                        frame_done_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_FILL;
                        in_cnt_reg     <= '0;
                        cr_reg         <= '0;
                        cc_reg         <= '0;
                        flush_cnt_reg  <= '0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
                        if (cc_reg == COL_LAST) begin
                            cc_reg <= '0;
                            cr_reg <= cr_reg + CNT_ONE;
                        end else begin
                            cc_reg <= cc_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_FILL;
                end
            endcase
        end
    end

    assign window_out = window_reg;
    assign win_valid  = win_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Testbench for window_3x3_gen on a 4x3 frame.
// The driver pushes the expected windows, computed from the padded image, into
// a scoreboard queue. A monitor pops the queue and compares on every win_valid.
// Directed frames are followed by randomized frames with random gaps and
// random mid-frame resets.

module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic [71:0] window_out;
    logic        win_valid;
    logic        busy;
    logic        frame_done;

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .window_out (window_out),
        .win_valid  (win_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] win;
        logic        fd;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  img [N];
    logic [71:0] got [N];
    int          got_cnt = 0;

    function automatic void check(string name, logic [71:0] act, logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // Reference: the 3x3 neighbourhood of centre k, with zeros outside the image.
    function automatic logic [71:0] ref_window(input int k);
        logic [71:0] w;
        int r;
        int c;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r = k / W + i - 1;
                c = k % W + j - 1;
                if (r >= 0 && r < H && c >= 0 && c < W)
                    w[8*(3*i+j) +: 8] = img[r*W + c];
            end
        end
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5,
                                          input int b6, input int b7, input int b8);
        return {b8[7:0], b7[7:0], b6[7:0], b5[7:0], b4[7:0],
                b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // Monitor: one line per window received.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_done && !win_valid)
                    check("frame_done_without_valid", {71'd0, win_valid}, 72'd1);
                if (win_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got %h required none", window_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", window_out, e.win);
                        check("frame_done", {71'd0, frame_done}, {71'd0, e.fd});
                        $display("window %0d: %h fd=%0b", got_cnt, window_out, frame_done);
                    end
                    if (got_cnt < N) got[got_cnt] = window_out;
                    got_cnt++;
                end
            end
        end
    end

    task automatic stall();
        pix_valid = 1'b0;
        pix_in = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        check("no_valid_on_stall", {71'd0, win_valid}, 72'd0);
    endtask

    // gap_mode: 0 = back-to-back, 1 = valid toggles 1,0,1,0, 2 = random gaps.
    // junk: drive pix_valid with value 99 throughout the flush.
    task automatic run_frame(input int n_pix, input int gap_mode, input bit junk);
        int n_emit;
        int bcount;
        exp_t e;
        n_emit = (n_pix == N) ? N : ((n_pix > W + 1) ? n_pix - W - 1 : 0);
        for (int k = 0; k < n_emit; k++) begin
            e.win = ref_window(k);
            e.fd  = (k == N - 1);
            exp_q.push_back(e);
        end
        got_cnt = 0;
        for (int idx = 0; idx < n_pix; idx++) begin
            if (gap_mode == 2) begin
                for (int s = 0; s < 4 && $urandom_range(0, 2) == 0; s++) stall();
            end
            pix_in = img[idx];
            pix_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            pix_valid = 1'b0;
            check("win_valid_on_accept", {71'd0, win_valid}, {71'd0, (idx >= W + 1)});
            check("busy_after_accept", {71'd0, busy}, {71'd0, (idx == N - 1)});
            if (gap_mode == 1 && idx < n_pix - 1) stall();
        end
        if (n_pix == N) begin
            bcount = 0;
            while (busy && bcount < 4 * W) begin
                pix_valid = junk;
                pix_in = 8'd99;
                @(posedge clk);
                @(negedge clk);
                bcount++;
            end
            pix_valid = 1'b0;
            check("busy_cycles", bcount, W + 1);
        end
        #1;
        check("windows_seen", got_cnt, n_emit);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_window", window_out, 72'd0);
        check("rst_valid", {71'd0, win_valid}, 72'd0);
        check("rst_busy", {71'd0, busy}, 72'd0);
        check("rst_frame_done", {71'd0, frame_done}, 72'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_outputs", {window_out, win_valid, busy, frame_done}, 75'd0);
        rst = 1'b1;
        exp_q.delete();
        got_cnt = 0;
        @(negedge clk);
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < N; i++) img[i] = 8'(base + i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Back-to-back run of 1..12.
        fill_seq(1);
        run_frame(N, 0, 1'b0);
        check("first_window", got[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("interior_window", got[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("last_window", got[N-1], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));

        // The same frame with pix_valid toggling.
        run_frame(N, 1, 1'b0);
        check("toggle_first_window", got[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("toggle_last_window", got[N-1], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));

        // Value 99 offered throughout the flush, then the second frame 101..112.
        run_frame(N, 0, 1'b1);
        fill_seq(101);
        run_frame(N, 0, 1'b0);
        check("second_frame_first", got[0], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));

        // Abort after 7 pixels, then a fresh frame.
        fill_seq(1);
        run_frame(7, 0, 1'b0);
        do_reset();
        run_frame(N, 0, 1'b0);
        check("after_abort_first", got[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));

        // Randomized frames, some of them aborted part-way.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom);
            if (f % 3 == 2) begin
                run_frame($urandom_range(1, N - 1), $urandom_range(0, 2), 1'b0);
                do_reset();
            end else begin
                run_frame(N, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator sitting directly upstream of `median_filter`. Accepts one 8-bit grayscale pixel per qualified cycle in raster order, buffers two image rows internally, and emits one zero-padded 3x3 window per pixel, centred on that pixel. After the last pixel of a frame it self-flushes so that exactly WIDTH*HEIGHT windows leave per frame.

## Interface
- `WIDTH`, 32'd410, pixels per row; must be ≥ 2.
- `HEIGHT`, 32'd361, rows per frame; must be ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset. Single clock domain; polarity and synchronicity are fixed.
- `pix_in`  input  8  incoming pixel, raster order (row 0, col 0 first).
- `pix_valid`  input  1  `pix_in` is accepted on any rising edge where this is 1 and `busy`=0.
- `window_out`  output  72  3x3 window. Byte n = `[8n+7:8n]`, row-major: n=0 is (r-1,c-1), n=4 is the centre (r,c), n=8 is (r+1,c+1).
- `win_valid`  output  1  `window_out` holds a new window this cycle; 1-cycle qualifier, no backpressure.
- `busy`  output  1  block is flushing; input is ignored.
- `frame_done`  output  1  1-cycle pulse coinciding with the final window of a frame.

## Operation
- Storage: a linear delay line of 2*WIDTH+3 bytes, shifting only on accepted pixels or flush cycles. Taps are at offsets {0,1,2}, {W,W+1,W+2}, {2W,2W+1,2W+2}, with offset 0 being the newest sample.
- Input counter `in_cnt`: 0..WIDTH*HEIGHT. Centre row counter `cr`: 0..HEIGHT-1. Centre column counter `cc`: 0..WIDTH-1.
- States:
  - FILL: accept pixels with no output. After WIDTH+1 accepted pixels, go to RUN.
  - RUN: each accepted pixel k+WIDTH+1 emits the window centred on linear index k. Advance `cc`, and on wrap advance `cr`. When `in_cnt` reaches WIDTH*HEIGHT, go to FLUSH.
  - FLUSH: `busy`=1 for WIDTH+1 consecutive cycles. Each cycle shifts in a zero and emits one window. The last flush cycle emits the window centred on WIDTH*HEIGHT-1 and pulses `frame_done`. Next state is FILL, with all counters cleared.
- Zero padding is done by masking on `cr`/`cc`, never by buffer contents:
  - `cr`=0 zeroes the top row; `cr`=HEIGHT-1 zeroes the bottom row.
  - `cc`=0 zeroes the left column; `cc`=WIDTH-1 zeroes the right column.
  - Corner windows apply both masks.
- Windows are emitted in strictly increasing centre index. Exactly WIDTH*HEIGHT windows are produced per frame.
- `pix_valid`=1 while `busy`=1: the pixel is dropped, the delay line does not shift, and `in_cnt` is unchanged. Upstream must hold the pixel.
- No arithmetic other than the counters. Counter widths are $clog2(WIDTH*HEIGHT+1), and all compares are unsigned.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - `window_out`=72'd0, `win_valid`=0, `busy`=0, `frame_done`=0.
  - State FILL, all counters 0.
  - Delay-line contents are don't-care, because masking covers the frame start.
- All outputs are registered. `window_out`/`win_valid` update on the same rising edge that accepts pixel k+WIDTH+1 (or the corresponding flush edge). The outputs are therefore visible one cycle after `pix_in` was presented.
- Latency from pixel k to its window:
  - WIDTH+1 accepted pixels in RUN.
  - WIDTH+1 cycles for the last row's tail in FLUSH.
- Gaps in `pix_valid` stall everything: no output, no shift.
- `busy` rises on the edge that accepts pixel WIDTH*HEIGHT-1 and falls on the edge emitting the last window. The first pixel of the next frame can be accepted on the following edge.
- Reset asserted mid-frame or mid-flush aborts immediately. The next frame starts from FILL with no stale windows emitted.

## Test plan
- WIDTH=4, HEIGHT=3, pixels 1..12 back-to-back. Required:
  - First `win_valid` on the edge accepting value 6, with bytes 0..8 = 0,0,0,0,1,2,0,5,6.
  - 12 windows total.
  - Last window = 7,8,0,11,12,0,0,0,0, coincident with `frame_done`.
  - `busy` high for 5 cycles.
- Same frame with `pix_valid` toggling 1,0,1,0. Required: windows identical in value and order to the back-to-back run, and `win_valid` never asserted on a stalled cycle.
- Interior window (centre value 6, r=1, c=1) in the 4x3 frame. Required: 1,2,3,5,6,7,9,10,11.
- `pix_valid`=1 with value 99 driven throughout FLUSH. Required: 99 never appears in any window, and the next frame's first window is correct.
- Two consecutive frames (1..12, then 101..112). Required: the second frame's first window is 0,0,0,0,101,102,0,105,106, with no data leaking from frame 1.
- `rst`=0 pulse after 7 pixels, then a fresh frame. Required:
  - All outputs 0 during reset.
  - Exactly 12 windows after reset.
  - First window as in scenario 1.
